// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Definitions shared by the hazard controller and its forwarding sub-module:
//   - forwarding-select encodings driven onto ForwardAE / ForwardBE
//   - multi-cycle unit FSM state type
//   - a packed bundle of the eight stall/flush controls, so the priority logic
//     can clear all of them with a single default assignment
// -----------------------------------------------------------------------------
package hazard_pkg;

  // Operand source for the E-stage ALU inputs.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value read in D
  localparam logic [1:0] FWD_W  = 2'b01;  // result being written back in W
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU result sitting in M

  // Iterative multiply/divide sequencer.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Per-stage pipeline-register controls.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hazard_ctl_t;

endpackage : hazard_pkg

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Chooses where one E-stage source operand comes from. The newer result in M
// wins over the older one in W. Register 0 never forwards because it always
// reads as zero.
//
// Ports:
//   rs_e         in  REG_AW  source register of the operand in E
//   rd_m, rd_w   in  REG_AW  destination registers in M and W
//   reg_write_m  in  1       M will write rd_m
//   reg_write_w  in  1       W will write rd_w
//   fwd_sel      out 2       FWD_M / FWD_W / FWD_RF
// -----------------------------------------------------------------------------
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_sel
);

  logic rs_nonzero;

  assign rs_nonzero = (rs_e != '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    fwd_sel = FWD_RF;
    if (rs_nonzero && reg_write_m && (rs_e == rd_m)) begin
      fwd_sel = FWD_M;
    end else if (rs_nonzero && reg_write_w && (rs_e == rd_w)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule : fwd_select

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a five-stage (F/D/E/M/W) RISC-V pipeline. It produces:
//   - operand forwarding selects for the two E-stage source operands
//   - load-use stalls and taken-branch flushes
//   - multi-cycle stalls for an iterative mul/div unit in E
//   - whole-pipe stalls while data memory inserts wait states in M
//   - saturating performance counters for stall cycles and branch flushes
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   Rs1D, Rs2D                  sources of the instruction in D
//   Rs1E, Rs2E, RdE             sources / destination in E
//   RegWriteE, ResultSrcE0      E writes a register / E is a load
//   MultiE                      E holds a multi-cycle op
//   PCSrcE                      taken branch or jump resolved in E
//   RdM, RdW                    destinations in M and W
//   RegWriteM, RegWriteW        write enables in M and W
//   MemAccessM, DMemReadyM      M accesses memory / memory is ready
//   CountClr                    synchronous clear of both counters
//   StallF/D/E/M                hold the register feeding that stage
//   FlushD/E/M/W                bubble the register feeding that stage
//   ForwardAE, ForwardBE        operand selects (see hazard_pkg)
//   StallCycles, FlushEvents    performance counters
//
// Control outputs are combinational from the inputs and the sequencer state;
// only the sequencer and the counters are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE0,
  input  logic              MultiE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemAccessM,
  input  logic              DMemReadyM,
  input  logic              CountClr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  // The down-counter needs at least one bit even for the short latencies.
  localparam int CNT_BITS = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

  // Entering BUSY already accounts for one stall cycle (the IDLE cycle), and
  // BUSY with cnt==0 is the release cycle, so we load MUL_LATENCY-2. For
  // MUL_LATENCY==2 this loads 0: one stall in IDLE, then straight to release.
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    CNT_BITS'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic mem_wait;
  logic lw_stall;

  assign mem_wait = MemAccessM & ~DMemReadyM;

  // A load in E whose result the instruction in D needs cannot be forwarded
  // in time; the D instruction waits one cycle and E gets a bubble.
  assign lw_stall = ResultSrcE0 & RegWriteE & (RdE != '0) &
                    ((Rs1D == RdE) | (Rs2D == RdE));

  // ---------------------------------------------------------------------------
  // Multi-cycle sequencer
  // ---------------------------------------------------------------------------
  mul_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q,   cnt_d;
  logic                mul_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    // A memory wait freezes the whole pipe, including the op in E, so the
    // sequencer must not advance either.
    if (!mem_wait) begin
      unique case (state_q)
        IDLE: begin
          if (MultiE && (MUL_LATENCY > 1)) begin
            mul_stall = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          // MultiE is not consulted here: once started, the sequence always
          // runs to its release cycle.
          if (cnt_q != '0) begin
            mul_stall = 1'b1;
            cnt_d     = cnt_q - CNT_BITS'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement or process order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall / flush priority
  // ---------------------------------------------------------------------------
  hazard_ctl_t ctl;
  logic        flush_evt;

  always_comb begin
    ctl       = '0;
    flush_evt = 1'b0;
    if (mem_wait) begin
      // Freeze F..M and drop the stalled M result into W as a bubble. Branch
      // and load-use are re-evaluated once memory is ready.
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (mul_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.flush_m = 1'b1;
    end else if (PCSrcE) begin
      // Squashing D makes any load-use hazard against it irrelevant.
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
      flush_evt   = 1'b1;
    end else if (lw_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  assign StallF = ctl.stall_f;
  assign StallD = ctl.stall_d;
  assign StallE = ctl.stall_e;
  assign StallM = ctl.stall_m;
  assign FlushD = ctl.flush_d;
  assign FlushE = ctl.flush_e;
  assign FlushM = ctl.flush_m;
  assign FlushW = ctl.flush_w;

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, clear wins over increment)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (CountClr) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (ctl.stall_f && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (flush_evt && (flush_events_q != '1)) begin
        flush_events_d = flush_events_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushEvents = flush_events_q;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Drives directed scenarios followed by random traffic. For every cycle the
// driver computes the expected outputs with a reference model and queues
// them; a monitor on the falling edge pops and compares against the DUT.
// The model tracks "stall cycles already served by the current multi-cycle
// op" and applies the hazard priority rules directly.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int LAT    = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              rst;
    logic [REG_AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic              regwe, ld, multi, pcsrc, regwm, regww, memacc, dready, clr;
  } stim_t;

  typedef struct packed {
    logic [7:0] ctl;  // StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW
    logic [1:0] fa;
    logic [1:0] fb;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REG_AW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
  logic [REG_AW-1:0] RdM = '0, RdW = '0;
  logic RegWriteE = 0, ResultSrcE0 = 0, MultiE = 0, PCSrcE = 0;
  logic RegWriteM = 0, RegWriteW = 0, MemAccessM = 0, DMemReadyM = 0, CountClr = 0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles, FlushEvents;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .MUL_LATENCY(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .MultiE(MultiE),
    .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .DMemReadyM(DMemReadyM), .CountClr(CountClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state: stall cycles served by the current multi-cycle op,
  // and the two event counts. "n_" values take effect at the next edge.
  // ---------------------------------------------------------------------------
  int served = 0, stalls = 0, flushes = 0;
  int n_served = 0, n_stalls = 0, n_flushes = 0;

  function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] rs,
                                           input stim_t s);
    if (rs != 0 && s.regwm && rs == s.rdm) return 2'b10;
    if (rs != 0 && s.regww && rs == s.rdw) return 2'b01;
    return 2'b00;
  endfunction

  // One pipeline cycle: apply stimulus just after the edge, queue expectation.
  task automatic cycle(input stim_t s);
    exp_t e;
    bit   mem_wait, lw, want_mul, mul_stall, br;
    @(posedge clk);
    #1;
    served = n_served; stalls = n_stalls; flushes = n_flushes;
    rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteE = s.regwe;
    ResultSrcE0 = s.ld; MultiE = s.multi; PCSrcE = s.pcsrc;
    RegWriteM = s.regwm; RegWriteW = s.regww; MemAccessM = s.memacc;
    DMemReadyM = s.dready; CountClr = s.clr;
    if (s.rst) begin
      served = 0; stalls = 0; flushes = 0;
    end

    mem_wait  = s.memacc && !s.dready;
    lw        = s.ld && s.regwe && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
    want_mul  = (served > 0) || s.multi;      // an op is in progress or starting
    mul_stall = !mem_wait && want_mul && (served < LAT - 1);
    br        = 1'b0;

    e.ctl = 8'b0;
    if (mem_wait)       e.ctl = 8'b1111_0001;
    else if (mul_stall) e.ctl = 8'b1110_0010;
    else if (s.pcsrc) begin
      e.ctl = 8'b0000_1100;
      br = 1'b1;
    end
    else if (lw)        e.ctl = 8'b1100_0100;
    e.fa = model_fwd(s.rs1e, s);
    e.fb = model_fwd(s.rs2e, s);
    e.sc = stalls;
    e.fe = flushes;
    exp_q.push_back(e);

    if (s.rst) begin
      n_served = 0; n_stalls = 0; n_flushes = 0;
    end else begin
      n_served = served;
      if (!mem_wait && want_mul) n_served = (served == LAT - 1) ? 0 : served + 1;
      if (s.clr) begin
        n_stalls = 0; n_flushes = 0;
      end else begin
        n_stalls  = (e.ctl[7] && stalls < CNT_MAX) ? stalls + 1 : stalls;
        n_flushes = (br && flushes < CNT_MAX) ? flushes + 1 : flushes;
      end
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, e.ctl);
        check("fwd_a", ForwardAE, e.fa);
        check("fwd_b", ForwardBE, e.fb);
        check("stall_cycles", StallCycles, e.sc);
        check("flush_events", FlushEvents, e.fe);
      end
    end
  end

  // Stimulus
  initial begin
    stim_t s;
    // Reset with all inputs low: every output must be zero.
    s = '0; s.rst = 1'b1;
    repeat (2) cycle(s);
    s = '0;
    cycle(s);

    // Forwarding: M beats W; register 0 never forwards; W alone.
    s = '0; s.rs1e = 5; s.rdm = 5; s.regwm = 1; s.rdw = 5; s.regww = 1;
    cycle(s);
    s.rs1e = 0; cycle(s);
    s.rs2e = 5; s.regwm = 0; cycle(s);

    // Load-use, then the same with a taken branch overriding it.
    s = '0; s.ld = 1; s.regwe = 1; s.rde = 7; s.rs2d = 7;
    cycle(s);
    s.pcsrc = 1; cycle(s);
    s = '0; cycle(s);

    // Multi-cycle op held in E: 3 stall cycles plus the release cycle.
    s = '0; s.multi = 1;
    repeat (LAT) cycle(s);
    s = '0; repeat (2) cycle(s);

    // Memory wait for two cycles in the middle of a BUSY sequence.
    s = '0; s.multi = 1;
    cycle(s);
    s.memacc = 1; s.dready = 0;
    repeat (2) cycle(s);
    s.memacc = 0;
    repeat (LAT) cycle(s);
    s = '0; cycle(s);

    // Reset mid-BUSY with MultiE held, then a fresh full sequence.
    s = '0; s.multi = 1;
    repeat (2) cycle(s);
    s.rst = 1; cycle(s);
    s.rst = 0; repeat (LAT) cycle(s);
    s = '0; cycle(s);

    // Continuous stall until the counter saturates, then clear.
    s = '0; s.memacc = 1; s.dready = 0;
    repeat (20) cycle(s);
    s.clr = 1; cycle(s);
    s = '0; repeat (2) cycle(s);

    // Random traffic on a small register range to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      s = '0;
      s.rst    = ($urandom_range(0, 199) == 0);
      s.rs1d   = REG_AW'($urandom_range(0, 7));
      s.rs2d   = REG_AW'($urandom_range(0, 7));
      s.rs1e   = REG_AW'($urandom_range(0, 7));
      s.rs2e   = REG_AW'($urandom_range(0, 7));
      s.rde    = REG_AW'($urandom_range(0, 7));
      s.rdm    = REG_AW'($urandom_range(0, 7));
      s.rdw    = REG_AW'($urandom_range(0, 7));
      s.regwe  = $urandom_range(0, 1) == 1;
      s.ld     = $urandom_range(0, 2) == 0;
      s.multi  = $urandom_range(0, 5) == 0;
      s.pcsrc  = $urandom_range(0, 5) == 0;
      s.regwm  = $urandom_range(0, 1) == 1;
      s.regww  = $urandom_range(0, 1) == 1;
      s.memacc = $urandom_range(0, 1) == 1;
      s.dready = $urandom_range(0, 3) != 0;
      s.clr    = $urandom_range(0, 39) == 0;
      cycle(s);
    end
    done = 1'b1;
  end

  // Wrap-up, with a hard time limit in case the stimulus never completes.
  initial begin
    fork
      wait (done);
      #2_000_000;
    join_any
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: stimulus did not complete");
    end
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
